lane_word_align: RTL and testbench
==================================

LANE_WORD_ALIGN -- requirements
Module: lane_word_align

Interface
REQ-001 SHALL have parameter LANES, default 8, meaning number of data lanes.
REQ-002 SHALL have parameter WORD_BITS, default 14, meaning deserialized word width; it must be even and at least 4.
REQ-003 SHALL have parameter TRAIN_PATTERN, default 14'h2C3A, meaning the expected training word (WORD_BITS wide).
REQ-004 SHALL have parameter LOCK_COUNT, default 16, meaning consecutive matching words required to declare lock.
REQ-005 SHALL derive localparam SW = $clog2(WORD_BITS) and HALF = WORD_BITS/2.
REQ-006 SHALL have port dco_clk, input, 1, the single clock for all logic.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port bit_rise, input, LANES, the rising-edge bit per lane, which is older than bit_fall in the same cycle.
REQ-009 SHALL have port bit_fall, input, LANES, the falling-edge bit per lane, already retimed to the dco_clk posedge.
REQ-010 SHALL have port bitslip_pulse, input, LANES, a manual one-bit slip request per lane (single-cycle pulse).
REQ-011 SHALL have port align_start, input, 1, a pulse that starts automatic alignment on all lanes.
REQ-012 SHALL have port word_data, output, LANES*WORD_BITS, aligned words with lane i at [i*WORD_BITS +: WORD_BITS] and MSB = oldest bit.
REQ-013 SHALL have port word_valid, output, 1, a single-cycle strobe qualifying word_data.
REQ-014 SHALL have ports lane_locked and lane_fail, output, LANES, giving per-lane alignment status.
REQ-015 SHALL have port slip_value, output, LANES*SW, the current bit offset per lane.

Function
REQ-016 SHALL shift each lane's 2*WORD_BITS-bit register every cycle as sr <= {sr[2W-3:0], bit_rise, bit_fall}.
REQ-017 SHALL run a word-phase counter 0..HALF-1 that is common to all lanes and wraps to 0.
REQ-018 SHALL, on the cycle after phase==HALF-1, register word_data[lane] = sr[k+W-1:k] (k = slip_value of that lane, sampled at the wrap) and pulse word_valid high for exactly one cycle.
REQ-019 SHALL apply a slip change only at the next word boundary; a word is never extracted with a mixed offset.
REQ-020 SHALL increment the slip offset modulo WORD_BITS, so WORD_BITS-1 -> 0, and each increment selects a window one bit older.
REQ-021 SHALL, for each lane, implement FSM states IDLE, SETTLE, CHECK, LOCKED and FAIL.
REQ-022 SHALL, on align_start in any state, move every lane to SETTLE with match_cnt=0, tries=0 and slip unchanged.
REQ-023 SHALL, in SETTLE, discard one extracted word and then go to CHECK.
REQ-024 SHALL, in CHECK on each word: if word==TRAIN_PATTERN, increment match_cnt, and go to LOCKED when match_cnt reaches LOCK_COUNT; otherwise increment slip, clear match_cnt, increment tries and go to SETTLE.
REQ-025 SHALL, in CHECK, go to FAIL with slip restored to its value at align_start when tries reaches WORD_BITS.
REQ-026 SHALL, in LOCKED, hold slip; a pattern mismatch does not unlock the lane, because payload data follows training.
REQ-027 SHALL drive lane_locked=1 only in LOCKED and lane_fail=1 only in FAIL.
REQ-028 SHALL ignore bitslip_pulse in SETTLE and CHECK.
REQ-029 SHALL, for bitslip_pulse in IDLE, LOCKED or FAIL, increment slip by 1 and move the lane to IDLE, clearing lane_locked and lane_fail.
REQ-030 SHALL give align_start priority over bitslip_pulse in the same cycle, and ignore the pulse.
REQ-031 SHALL count a second bitslip_pulse within the same word period as an additional slip, with net slip = number of pulses modulo WORD_BITS.

Reset
REQ-032 SHALL, while rst=1, asynchronously clear shift registers, phase counter, slip_value, word_data, word_valid, lane_locked, lane_fail, match_cnt and tries to 0, with every FSM in IDLE.
REQ-033 SHALL, on rst deassertion, extract the first word HALF cycles later, and SHALL not perform any alignment until align_start.
REQ-034 SHALL abandon any alignment in progress when rst is asserted, and SHALL not resume it after release.

Verification
REQ-035 SHALL be covered by a test where W=14, each lane sends TRAIN_PATTERN with lane i delayed by i bits, then align_start -> every lane reaches lane_locked with slip_value[i] = (14-i)%14 and word_data = 14'h2C3A.
REQ-036 SHALL be covered by a test that sends a constant 0 pattern and pulses align_start -> lane_fail=1 after 14 tries, slip_value back to its start value, and lane_locked=0.
REQ-037 SHALL be covered by a test with slip=13 and one bitslip_pulse -> slip_value=0, and the next word equals the unslipped extraction.
REQ-038 SHALL be covered by a test that asserts bitslip_pulse and align_start in the same cycle -> the pulse is ignored and the lane enters SETTLE with slip unchanged.
REQ-039 SHALL be covered by a test that asserts rst during CHECK -> all outputs are 0 within the same cycle, the FSM is in IDLE, and word_valid resumes HALF cycles after release.
REQ-040 SHALL be covered by a test that checks word_valid spacing -> exactly one pulse every 7 cycles at W=14 across slips and state changes.

Source files
------------

// File: rtl/lane_word_align_if.sv
// Lane bus for lane_word_align: raw DDR bits and slip/align controls in,
// aligned words and per-lane alignment status out.
interface lane_word_align_if #(
  parameter int LANES     = 8,
  parameter int WORD_BITS = 14
);
  localparam int SW = $clog2(WORD_BITS);

  logic [LANES-1:0]           bit_rise;
  logic [LANES-1:0]           bit_fall;
  logic [LANES-1:0]           bitslip_pulse;
  logic                       align_start;
  logic [LANES*WORD_BITS-1:0] word_data;
  logic                       word_valid;
  logic [LANES-1:0]           lane_locked;
  logic [LANES-1:0]           lane_fail;
  logic [LANES*SW-1:0]        slip_value;

  modport master (
    output bit_rise, bit_fall, bitslip_pulse, align_start,
    input  word_data, word_valid, lane_locked, lane_fail, slip_value
  );

  modport slave (
    input  bit_rise, bit_fall, bitslip_pulse, align_start,
    output word_data, word_valid, lane_locked, lane_fail, slip_value
  );
endinterface

// File: rtl/lane_word_align.sv
// Per-lane DDR deserializer with word-boundary bitslip and automatic
// training-pattern alignment; all lanes share one word-phase counter.
module lane_word_align #(
  parameter int                   LANES         = 8,
  parameter int                   WORD_BITS     = 14,
  parameter logic [WORD_BITS-1:0] TRAIN_PATTERN = 14'h2C3A,
  parameter int                   LOCK_COUNT    = 16
) (
  input  logic             dco_clk,
  input  logic             rst,
  lane_word_align_if.slave bus
);
  localparam int SW      = $clog2(WORD_BITS);
  localparam int HALF    = WORD_BITS / 2;
  localparam int SR_BITS = 2 * WORD_BITS;
  localparam int PW      = $clog2(HALF);
  localparam int MW      = $clog2(LOCK_COUNT + 1);
  localparam int TW      = $clog2(WORD_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_LOCKED,
    S_FAIL
  } state_t;

  logic [PW-1:0] r_phase;
  logic          r_valid;
  logic          w_wrap;

  assign w_wrap         = (r_phase == PW'(HALF - 1));
  assign bus.word_valid = r_valid;

  always_ff @(posedge dco_clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
      r_valid <= 1'b0;
    end else begin
      r_phase <= w_wrap ? '0 : r_phase + PW'(1);
      r_valid <= w_wrap;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    // The two newest history bits are the pair arriving this cycle, so the
    // register holds only the older 2W-2; words are cut from the post-shift view.
    logic [SR_BITS-3:0]   r_sr;
    logic [SR_BITS-1:0]   w_sr_nxt;
    logic [WORD_BITS-1:0] w_word;
    logic [WORD_BITS-1:0] r_word;
    logic [SW-1:0]        r_slip;
    logic [SW-1:0]        r_slip_start;
    logic [SW-1:0]        w_slip_inc;
    logic [MW-1:0]        r_match;
    logic [TW-1:0]        r_tries;
    logic                 r_locked;
    logic                 r_fail;
    logic                 w_manual_ok;
    state_t               r_state;

    assign w_sr_nxt    = {r_sr, bus.bit_rise[g], bus.bit_fall[g]};
    assign w_word      = w_sr_nxt[r_slip +: WORD_BITS];
    assign w_slip_inc  = (r_slip == SW'(WORD_BITS - 1)) ? '0 : r_slip + SW'(1);
    assign w_manual_ok = (r_state == S_IDLE) || (r_state == S_LOCKED) ||
                         (r_state == S_FAIL);

    assign bus.word_data[g*WORD_BITS +: WORD_BITS] = r_word;
    assign bus.slip_value[g*SW +: SW]              = r_slip;
    assign bus.lane_locked[g]                      = r_locked;
    assign bus.lane_fail[g]                        = r_fail;

    always_ff @(posedge dco_clk or posedge rst) begin
      if (rst) begin
        r_sr   <= '0;
        r_word <= '0;
      end else begin
        r_sr <= w_sr_nxt[SR_BITS-3:0];
        if (w_wrap) r_word <= w_word;
      end
    end

    always_ff @(posedge dco_clk or posedge rst) begin
      if (rst) begin
        r_state      <= S_IDLE;
        r_slip       <= '0;
        r_slip_start <= '0;
        r_match      <= '0;
        r_tries      <= '0;
        r_locked     <= 1'b0;
        r_fail       <= 1'b0;
      end else if (bus.align_start) begin
        r_state      <= S_SETTLE;
        r_slip_start <= r_slip;
        r_match      <= '0;
        r_tries      <= '0;
        r_locked     <= 1'b0;
        r_fail       <= 1'b0;
      end else if (bus.bitslip_pulse[g] && w_manual_ok) begin
        r_state  <= S_IDLE;
        r_slip   <= w_slip_inc;
        r_locked <= 1'b0;
        r_fail   <= 1'b0;
      end else if (w_wrap) begin
        case (r_state)
          S_SETTLE: r_state <= S_CHECK;
          S_CHECK: begin
            if (w_word == TRAIN_PATTERN) begin
              r_match <= r_match + MW'(1);
              if (r_match == MW'(LOCK_COUNT - 1)) begin
                r_state  <= S_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_match <= '0;
              r_tries <= r_tries + TW'(1);
              // Every offset tried: give up and return to where the search began.
              if (r_tries == TW'(WORD_BITS - 1)) begin
                r_state <= S_FAIL;
                r_fail  <= 1'b1;
                r_slip  <= r_slip_start;
              end else begin
                r_state <= S_SETTLE;
                r_slip  <= w_slip_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lane_word_align.sv
// Directed bench for lane_word_align: lane i carries the training word delayed
// by i bits; checks alignment, manual slip, priority, failure and reset.
module tb_lane_word_align;
  localparam int LANES = 8;
  localparam int W     = 14;
  localparam int SW    = 4;
  localparam logic [W-1:0] P = 14'h2C3A;

  logic dco_clk = 1'b0;
  logic rst     = 1'b1;
  bit   train   = 1'b1;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  logic [W-1:0] pat = P;

  always #5 dco_clk = ~dco_clk;

  lane_word_align_if #(.LANES(LANES), .WORD_BITS(W)) bus();

  lane_word_align #(
    .LANES(LANES), .WORD_BITS(W), .TRAIN_PATTERN(P), .LOCK_COUNT(16)
  ) dut (
    .dco_clk(dco_clk),
    .rst    (rst),
    .bus    (bus)
  );

  function automatic logic bit_at(int lane, int n);
    if (!train) return 1'b0;
    return pat[W - 1 - ((n - lane + W * LANES) % W)];
  endfunction

  task automatic drive(int p);
    for (int i = 0; i < LANES; i++) begin
      bus.bit_rise[i] = bit_at(i, 2 * p);
      bus.bit_fall[i] = bit_at(i, 2 * p + 1);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge dco_clk); #1;
      if (bus.word_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("word_valid_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_words(int n);
    for (int k = 0; k < n; k++) wait_valid();
  endtask

  task automatic wait_all(bit want_fail);
    for (int k = 0; k < 60; k++) begin
      wait_valid();
      if ((want_fail ? bus.lane_fail : bus.lane_locked) == 8'hFF) break;
    end
    chk(want_fail ? "fail_all" : "lock_all",
        32'(want_fail ? bus.lane_fail : bus.lane_locked), 32'hFF);
  endtask

  task automatic pulse_align();
    bus.align_start = 1'b1;
    @(posedge dco_clk); #1;
    bus.align_start = 1'b0;
  endtask

  task automatic check_slips(string tag);
    for (int i = 0; i < LANES; i++)
      chk($sformatf("%s_l%0d", tag, i), 32'(bus.slip_value[i*SW +: SW]), 32'((W - i) % W));
  endtask

  task automatic release_and_time(string tag);
    @(negedge dco_clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge dco_clk);
    #1 chk({tag, "_valid_early"}, 32'(bus.word_valid), 32'd0);
    @(posedge dco_clk); #1;
    chk({tag, "_valid_half"}, 32'(bus.word_valid), 32'd1);
  endtask

  // Stream driver: bit pair index counts posedges since reset release.
  initial begin
    int pos = 0;
    drive(0);
    forever begin
      @(posedge dco_clk); #1;
      if (rst) pos = 0;
      else     pos++;
      drive(pos);
    end
  end

  // word_valid spacing monitor
  initial begin
    int gap   = 0;
    bit armed = 1'b0;
    forever begin
      @(negedge dco_clk);
      if (rst) armed = 1'b0;
      else if (bus.word_valid) begin
        if (armed) begin
          n_cmp++;
          assert (gap == 7) else begin
            n_bad++;
            $error("FAIL valid_spacing observed=%0d expected=7", gap);
          end
        end
        gap   = 1;
        armed = 1'b1;
      end else gap++;
    end
  end

  initial begin
    logic [31:0] exp_slip;
    bus.bitslip_pulse = '0;
    bus.align_start   = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge dco_clk);
    #1;
    chk("rst_word_data", 32'(|bus.word_data), 32'd0);
    chk("rst_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_locked", 32'(bus.lane_locked), 32'd0);
    chk("rst_fail", 32'(bus.lane_fail), 32'd0);
    chk("rst_slip", 32'(bus.slip_value), 32'd0);

    // First word after reset, all lanes unslipped
    release_and_time("boot");
    chk("boot_word_l0", 32'(bus.word_data[0 +: W]), 32'h2C3A);
    chk("boot_word_l1", 32'(bus.word_data[W +: W]), 32'h161D);
    chk("boot_word_l2", 32'(bus.word_data[2*W +: W]), 32'h2B0E);
    wait_words(3);
    chk("idle_no_lock", 32'(bus.lane_locked), 32'd0);

    // Automatic alignment
    pulse_align();
    wait_all(1'b0);
    check_slips("lock_slip");
    wait_valid();
    for (int i = 0; i < LANES; i++)
      chk($sformatf("lock_word_l%0d", i), 32'(bus.word_data[i*W +: W]), 32'h2C3A);
    chk("lock_no_fail", 32'(bus.lane_fail), 32'd0);

    // Manual slip: lane1 13->0 (wrap), lane2 two pulses in one word 12->0
    bus.bitslip_pulse = 8'h02;
    @(posedge dco_clk); #1;
    bus.bitslip_pulse = 8'h04;
    chk("slip_wrap_l1", 32'(bus.slip_value[SW +: SW]), 32'd0);
    chk("slip_unlock_l1", 32'(bus.lane_locked), 32'hFD);
    @(posedge dco_clk); #1;
    bus.bitslip_pulse = 8'h00;
    @(posedge dco_clk); #1;
    bus.bitslip_pulse = 8'h04;
    @(posedge dco_clk); #1;
    bus.bitslip_pulse = 8'h00;
    chk("slip_double_l2", 32'(bus.slip_value[2*SW +: SW]), 32'd0);
    chk("slip_locked", 32'(bus.lane_locked), 32'hF9);
    wait_valid();
    chk("slip_word_l0", 32'(bus.word_data[0 +: W]), 32'h2C3A);
    chk("slip_word_l1", 32'(bus.word_data[W +: W]), 32'h161D);
    chk("slip_word_l2", 32'(bus.word_data[2*W +: W]), 32'h2B0E);

    // align_start beats bitslip_pulse in the same cycle
    bus.bitslip_pulse = 8'h01;
    bus.align_start   = 1'b1;
    @(posedge dco_clk); #1;
    bus.bitslip_pulse = 8'h00;
    bus.align_start   = 1'b0;
    chk("prio_slip_l0", 32'(bus.slip_value[0 +: SW]), 32'd0);
    chk("prio_locked", 32'(bus.lane_locked), 32'd0);
    wait_words(16);
    chk("prio_lock_early_l0", 32'(bus.lane_locked[0]), 32'd0);
    wait_valid();
    chk("prio_lock_l0", 32'(bus.lane_locked[0]), 32'd1);
    chk("prio_slip_kept_l0", 32'(bus.slip_value[0 +: SW]), 32'd0);
    wait_all(1'b0);
    check_slips("relock_slip");

    // Payload after lock does not unlock
    train = 1'b0;
    wait_words(3);
    chk("payload_keeps_lock", 32'(bus.lane_locked), 32'hFF);

    // No pattern: fail after 14 tries with slip restored
    pulse_align();
    wait_words(27);
    chk("fail_early", 32'(bus.lane_fail), 32'd0);
    wait_valid();
    chk("fail_28th_word", 32'(bus.lane_fail), 32'hFF);
    chk("fail_locked", 32'(bus.lane_locked), 32'd0);
    exp_slip = '0;
    for (int i = 0; i < LANES; i++) exp_slip[i*SW +: SW] = 4'((W - i) % W);
    chk("fail_slip_restored", 32'(bus.slip_value), exp_slip);

    // Reset in the middle of CHECK
    train = 1'b1;
    pulse_align();
    wait_words(3);
    @(posedge dco_clk); #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_word_data", 32'(|bus.word_data), 32'd0);
    chk("mid_rst_valid", 32'(bus.word_valid), 32'd0);
    chk("mid_rst_locked", 32'(bus.lane_locked), 32'd0);
    chk("mid_rst_fail", 32'(bus.lane_fail), 32'd0);
    chk("mid_rst_slip", 32'(bus.slip_value), 32'd0);
    repeat (2) @(posedge dco_clk);
    release_and_time("rerelease");
    wait_words(20);
    chk("no_resume_locked", 32'(bus.lane_locked), 32'd0);
    chk("no_resume_fail", 32'(bus.lane_fail), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
